// File: rtl/tag_inflight_table.sv
// tag_inflight_table: pairs dispatches with allocator tags, keeps per-tag metadata and
// returns tagged results to writeback while releasing the tag. TAG_INFLIGHT_CNT_EN adds occupancy counters.
module tag_inflight_table #(
  parameter int NumTags   = 16,
  parameter int MetaWidth = 8,
  parameter int DataWidth = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         tag_valid_i,
  input  logic [$clog2(NumTags)-1:0]   tag_i,
  output logic                         tag_get_o,
  input  logic                         disp_valid_i,
  input  logic [MetaWidth-1:0]         disp_meta_i,
  output logic                         disp_ready_o,
  output logic [$clog2(NumTags)-1:0]   disp_tag_o,
  input  logic                         rsp_valid_i,
  input  logic [$clog2(NumTags)-1:0]   rsp_tag_i,
  input  logic [DataWidth-1:0]         rsp_data_i,
  output logic                         rsp_ready_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [MetaWidth-1:0]         out_meta_o,
  output logic [DataWidth-1:0]         out_data_o,
  output logic [$clog2(NumTags)-1:0]   out_tag_o,
  output logic                         free_o,
  output logic [$clog2(NumTags)-1:0]   free_tag_o,
  output logic                         err_o
`ifdef TAG_INFLIGHT_CNT_EN
  ,
  output logic [$clog2(NumTags+1)-1:0] inflight_cnt_o,
  output logic [$clog2(NumTags+1)-1:0] max_inflight_o
`endif
);

  logic [NumTags-1:0]   busy_q;
  logic [NumTags-1:0]   busy_d;
  logic [MetaWidth-1:0] meta_q [NumTags];
  logic                 alloc;
  logic                 rsp_fire;
  logic                 same_tag;
  logic                 rsp_hit;

  assign disp_ready_o = tag_valid_i;
  assign tag_get_o    = disp_valid_i && tag_valid_i;
  assign disp_tag_o   = tag_i;
  assign alloc        = tag_get_o;

  assign rsp_ready_o  = !out_valid_o || out_ready_i;
  assign rsp_fire     = rsp_valid_i && rsp_ready_o;
  // A tag being offered is by definition not in flight, so a same-tag response cannot hit.
  assign same_tag     = alloc && (tag_i == rsp_tag_i);
  assign rsp_hit      = busy_q[rsp_tag_i] && !same_tag;

  // Set after clear: a same-cycle allocation of the responding tag keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (rsp_fire) busy_d[rsp_tag_i] = 1'b0;
    if (alloc)    busy_d[tag_i]     = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q      <= '0;
      out_valid_o <= 1'b0;
      out_meta_o  <= '0;
      out_data_o  <= '0;
      out_tag_o   <= '0;
      free_o      <= 1'b0;
      free_tag_o  <= '0;
      err_o       <= 1'b0;
    end else begin
      busy_q <= busy_d;
      free_o <= rsp_fire && rsp_hit;
      if (rsp_fire) begin
        out_valid_o <= 1'b1;
        out_meta_o  <= meta_q[rsp_tag_i];
        out_data_o  <= rsp_data_i;
        out_tag_o   <= rsp_tag_i;
        free_tag_o  <= rsp_tag_i;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
      if ((alloc && busy_q[tag_i]) || (rsp_fire && !rsp_hit)) err_o <= 1'b1;
    end
  end

  // Metadata needs no reset; busy_q decides whether an entry is meaningful.
  always_ff @(posedge clk_i) begin
    if (alloc) meta_q[tag_i] <= disp_meta_i;
  end

`ifdef TAG_INFLIGHT_CNT_EN
  localparam int CntW = $clog2(NumTags + 1);

  logic [CntW-1:0] cnt_d;
  logic            cnt_inc;
  logic            cnt_dec;

  assign cnt_inc = alloc && !busy_q[tag_i];
  assign cnt_dec = rsp_fire && rsp_hit;

  always_comb begin
    cnt_d = inflight_cnt_o;
    if (cnt_inc && !cnt_dec)      cnt_d = inflight_cnt_o + CntW'(1);
    else if (!cnt_inc && cnt_dec) cnt_d = inflight_cnt_o - CntW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_cnt_o <= '0;
      max_inflight_o <= '0;
    end else begin
      inflight_cnt_o <= cnt_d;
      if (cnt_d > max_inflight_o) max_inflight_o <= cnt_d;
    end
  end
`endif

endmodule
